grid_state_ram: RTL and testbench

GRID_STATE_RAM -- requirements
Module: grid_state_ram

---
 rtl/grid_state_ram.sv | 163 ++++++++++++++++
 tb/tb_grid_state_ram.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_state_ram.sv
//-----------------------------------------------------------------------------
// +---------------------------------------------------------------------------+
// | Module   : grid_state_ram                                                 |
// | Purpose  : Register-based ROWS x COLS grid of CELL_W-bit cell states with |
// |            a CPU store/load port, a registered display read port and a    |
// |            row-per-cycle clear sweep for game-over.                       |
// | Optional : define GRID_OCC_COUNT_EN to add the occ_count output, a        |
// |            registered count of nonzero cells.                             |
// | Ports    : clk, rst (sync, active-low)                                    |
// |            wr_en/wr_x/wr_y/wr_data   - CPU store                          |
// |            rd_en/rd_addr -> rd_data/rd_valid - CPU load, latency 1        |
// |            disp_x/disp_y -> disp_state - display read, latency 1          |
// |            clear -> busy - clear sweep request / in-progress flag         |
// |            occ_count (optional)      - number of nonzero cells            |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module grid_state_ram #(
  parameter int COLS   = 20,
  parameter int ROWS   = 15,
  parameter int CELL_W = 4,
  parameter int XW     = 5,
  parameter int YW     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [XW-1:0]         wr_x,
  input  logic [YW-1:0]         wr_y,
  input  logic [CELL_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [YW+XW-1:0]      rd_addr,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  input  logic [XW-1:0]         disp_x,
  input  logic [YW-1:0]         disp_y,
  output logic [CELL_W-1:0]     disp_state,
  input  logic                  clear,
  output logic                  busy
`ifdef GRID_OCC_COUNT_EN
  ,
  output logic [$clog2(ROWS*COLS+1)-1:0] occ_count
`endif
);

  localparam int PAD_W = 32 - YW - XW - CELL_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state;
  logic [YW-1:0]       clear_row;
  logic [CELL_W-1:0]   cells [ROWS][COLS];

  logic [CELL_W-1:0]   rd_cell;
  logic [CELL_W-1:0]   disp_cell;
  logic [CELL_W-1:0]   wr_old;
  logic                wr_hit;
  logic                wr_accept;

  // Address decode by matching against every cell: an out-of-range
  // coordinate simply matches nothing and reads back as zero.
  always_comb begin
    rd_cell   = '0;
    disp_cell = '0;
    wr_old    = '0;
    wr_hit    = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (rd_addr == {YW'(r), XW'(c)})
          rd_cell = cells[r][c];
        if (disp_y == YW'(r) && disp_x == XW'(c))
          disp_cell = cells[r][c];
        if (wr_y == YW'(r) && wr_x == XW'(c)) begin
          wr_old = cells[r][c];
          wr_hit = 1'b1;
        end
      end
    end
  end

  // Stores are only taken in IDLE; everything during a sweep is dropped.
  assign wr_accept = wr_en && wr_hit && (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      clear_row  <= '0;
      busy       <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      disp_state <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          cells[r][c] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear) begin
            state     <= ST_CLEAR;
            clear_row <= '0;
            busy      <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clear_row == YW'(ROWS - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            clear_row <= clear_row + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Sweep zeroing outranks a CPU store to the same cell.
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (state == ST_CLEAR && clear_row == YW'(r))
            cells[r][c] <= '0;
          else if (wr_accept && wr_y == YW'(r) && wr_x == XW'(c))
            cells[r][c] <= wr_data;
        end
      end

      // Reads sample the array before this edge's update, so a same-cycle
      // store to the same cell returns the old value.
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= {{PAD_W{1'b0}}, rd_addr, (busy ? {CELL_W{1'b0}} : rd_cell)};

      disp_state <= disp_cell;
    end
  end

`ifdef GRID_OCC_COUNT_EN
  localparam int OCC_W = $clog2(ROWS*COLS+1);

  // Counter is forced to zero from the clear request through the sweep, so
  // it is already correct when the sweep finishes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      occ_count <= '0;
    end else if ((state == ST_IDLE && clear) || state == ST_CLEAR) begin
      occ_count <= '0;
    end else if (wr_accept) begin
      if (wr_old == '0 && wr_data != '0)
        occ_count <= occ_count + OCC_W'(1);
      else if (wr_old != '0 && wr_data == '0)
        occ_count <= occ_count - OCC_W'(1);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_grid_state_ram.sv
//-----------------------------------------------------------------------------
// +---------------------------------------------------------------------------+
// | Module   : tb_grid_state_ram                                              |
// | Purpose  : Directed self-checking bench for grid_state_ram (default       |
// |            parameters: 20 x 15 cells, 4-bit state, 5-bit coordinates).   |
// |            occ_count checks are included when GRID_OCC_COUNT_EN is set.  |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_grid_state_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_x;
  logic [4:0]  wr_y;
  logic [3:0]  wr_data;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [4:0]  disp_x;
  logic [4:0]  disp_y;
  logic [3:0]  disp_state;
  logic        clear;
  logic        busy;
`ifdef GRID_OCC_COUNT_EN
  logic [8:0]  occ_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  grid_state_ram dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .disp_x     (disp_x),
    .disp_y     (disp_y),
    .disp_state (disp_state),
    .clear      (clear),
    .busy       (busy)
`ifdef GRID_OCC_COUNT_EN
    ,
    .occ_count  (occ_count)
`endif
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are stable 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cell(input int x, input int y, input logic [3:0] d);
    wr_x    = 5'(x);
    wr_y    = 5'(y);
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_en = 0; wr_x = 0; wr_y = 0; wr_data = 0;
    rd_en = 0; rd_addr = 0; disp_x = 0; disp_y = 0; clear = 0;
    repeat (3) tick();
    n_vec++;
    if (rd_data !== 32'h0 || rd_valid !== 1'b0 || busy !== 1'b0 || disp_state !== 4'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got rd_data=%h rd_valid=%b busy=%b disp=%h, want 0/0/0/0",
               rd_data, rd_valid, busy, disp_state);
    end
`ifdef GRID_OCC_COUNT_EN
    n_vec++;
    if (occ_count !== 9'd0) begin
      n_err++;
      $display("FAIL reset_occ: got %0d want 0", occ_count);
    end
`endif
    rst = 1'b1;
    tick();
  endtask

`ifdef GRID_OCC_COUNT_EN
  task automatic test_occ_count();
    write_cell(0, 0, 4'h1);
    write_cell(1, 0, 4'h2);
    write_cell(2, 0, 4'h3);
    n_vec++;
    if (occ_count !== 9'd3) begin
      n_err++;
      $display("FAIL occ_three: got %0d want 3", occ_count);
    end
    write_cell(1, 0, 4'h0);
    n_vec++;
    if (occ_count !== 9'd2) begin
      n_err++;
      $display("FAIL occ_zeroed: got %0d want 2", occ_count);
    end
    write_cell(0, 0, 4'h7);
    n_vec++;
    if (occ_count !== 9'd2) begin
      n_err++;
      $display("FAIL occ_rewrite: got %0d want 2", occ_count);
    end
    // Out-of-range store must not count.
    write_cell(20, 0, 4'h9);
    n_vec++;
    if (occ_count !== 9'd2) begin
      n_err++;
      $display("FAIL occ_out_of_range: got %0d want 2", occ_count);
    end
  endtask
`endif

  task automatic test_write_read();
    write_cell(3, 2, 4'hA);
    rd_en   = 1'b1;
    rd_addr = {5'd2, 5'd3};
    tick();
    rd_en   = 1'b0;
    // {y=2,x=3} packs to 10'h043; with the 4-bit cell field: 32'h0000_043A.
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h0000_043A) begin
      n_err++;
      $display("FAIL load_basic: got valid=%b data=%h want 1/0000043a", rd_valid, rd_data);
    end
    tick();
    n_vec++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h0000_043A) begin
      n_err++;
      $display("FAIL load_hold: got valid=%b data=%h want 0/0000043a", rd_valid, rd_data);
    end
  endtask

  task automatic test_out_of_range();
    write_cell(20, 2, 4'hF);
    rd_en   = 1'b1;
    rd_addr = {5'd2, 5'd20};
    tick();
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h0000_0540) begin
      n_err++;
      $display("FAIL load_oob: got valid=%b data=%h want 1/00000540", rd_valid, rd_data);
    end
    rd_addr = {5'd2, 5'd19};
    tick();
    n_vec++;
    if (rd_data !== 32'h0000_0530) begin
      n_err++;
      $display("FAIL oob_neighbor: got %h want 00000530", rd_data);
    end
    rd_addr = {5'd2, 5'd3};
    tick();
    rd_en = 1'b0;
    n_vec++;
    if (rd_data !== 32'h0000_043A) begin
      n_err++;
      $display("FAIL oob_no_alias: got %h want 0000043a", rd_data);
    end
    disp_x = 5'd0; disp_y = 5'd15;
    write_cell(0, 15, 4'h6);
    tick();
    n_vec++;
    if (disp_state !== 4'h0) begin
      n_err++;
      $display("FAIL disp_oob_row: got %h want 0", disp_state);
    end
  endtask

  task automatic test_collision();
    disp_x = 5'd5; disp_y = 5'd1;
    tick();
    n_vec++;
    if (disp_state !== 4'h0) begin
      n_err++;
      $display("FAIL disp_initial: got %h want 0", disp_state);
    end
    write_cell(5, 1, 4'h5);
    n_vec++;
    if (disp_state !== 4'h0) begin
      n_err++;
      $display("FAIL disp_same_cycle: got %h want 0 (old value)", disp_state);
    end
    tick();
    n_vec++;
    if (disp_state !== 4'h5) begin
      n_err++;
      $display("FAIL disp_next_cycle: got %h want 5", disp_state);
    end
    // Load and store to the same cell in one cycle.
    rd_en = 1'b1; rd_addr = {5'd1, 5'd5};
    write_cell(5, 1, 4'h7);
    n_vec++;
    if (rd_data !== 32'h0000_0255) begin
      n_err++;
      $display("FAIL load_same_cycle: got %h want 00000255", rd_data);
    end
    tick();
    rd_en = 1'b0;
    n_vec++;
    if (rd_data !== 32'h0000_0257) begin
      n_err++;
      $display("FAIL load_after_write: got %h want 00000257", rd_data);
    end
  endtask

  task automatic test_clear();
    int n;
    int bad;
    for (int y = 0; y < 15; y++)
      for (int x = 0; x < 20; x++)
        write_cell(x, y, 4'h1);
`ifdef GRID_OCC_COUNT_EN
    n_vec++;
    if (occ_count !== 9'd300) begin
      n_err++;
      $display("FAIL occ_full: got %0d want 300", occ_count);
    end
`endif
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL clear_busy_start: got %b want 1", busy);
    end
    // Keep trying to store into row 0 for the whole sweep.
    wr_x = 5'd0; wr_y = 5'd0; wr_data = 4'hF; wr_en = 1'b1;
    n = 0;
    while (busy && n < 40) begin
      rd_en   = (n == 2);
      rd_addr = {5'd14, 5'd0};
      clear   = (n == 5);
      tick();
      n++;
      if (n == 3) begin
        n_vec++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0000_1C00) begin
          n_err++;
          $display("FAIL load_while_busy: got valid=%b data=%h want 1/00001c00", rd_valid, rd_data);
        end
      end
    end
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    n_vec++;
    if (n != 15) begin
      n_err++;
      $display("FAIL clear_busy_len: got %0d cycles want 15", n);
    end
`ifdef GRID_OCC_COUNT_EN
    n_vec++;
    if (occ_count !== 9'd0) begin
      n_err++;
      $display("FAIL occ_after_clear: got %0d want 0", occ_count);
    end
`endif
    bad = 0;
    for (int y = 0; y < 15; y++)
      for (int x = 0; x < 20; x++) begin
        disp_x = 5'(x); disp_y = 5'(y);
        tick();
        if (disp_state !== 4'h0) bad++;
      end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL clear_all_zero: got %0d nonzero cells want 0", bad);
    end
  endtask

  task automatic test_reset_mid_sweep();
    write_cell(4, 10, 4'h9);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (7) tick();   // rows 0..6 done, row 7 is next
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_sweep_busy: got %b want 1", busy);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_vec++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'h0) begin
      n_err++;
      $display("FAIL mid_sweep_reset: got busy=%b valid=%b data=%h want 0/0/0", busy, rd_valid, rd_data);
    end
    disp_x = 5'd4; disp_y = 5'd10;
    tick();
    n_vec++;
    if (disp_state !== 4'h0) begin
      n_err++;
      $display("FAIL mid_sweep_cell: got %h want 0", disp_state);
    end
    // Store is accepted immediately, so the FSM is back in IDLE.
    disp_x = 5'd1; disp_y = 5'd1;
    write_cell(1, 1, 4'h3);
    tick();
    n_vec++;
    if (disp_state !== 4'h3 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got disp=%h busy=%b want 3/0", disp_state, busy);
    end
  endtask

  initial begin
    test_reset();
`ifdef GRID_OCC_COUNT_EN
    test_occ_count();
`endif
    test_write_read();
    test_out_of_range();
    test_collision();
    test_clear();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
